// File: rtl/ct_had_dbginfo_rd_ctrl.sv
// Read-side controller for the HAD debug-info snapshot FIFOs.
// Two requesters (0: JTAG/DM register path, 1: trace/system-bus path) share
// the FIFOs through a round-robin arbiter. The winner gets a one-cycle grant.
// The controller then issues exactly DBG_DEPTH read pulses into the selected
// FIFO and forwards the first len words over a valid/ack handshake.
//
// Handshake: dump_data_vld rises with a new word in dump_data. Both stay
// stable until the cycle in which dump_data_ack is high. A word is consumed
// on the clock edge where vld and ack are both high. ack without vld is
// ignored.
//
// The FIFO is always drained completely, so its read pointer wraps back to
// zero after every dump. The DONE state and the first IDLE cycle after it
// never pulse a read enable, which gives the FIFO a cycle to clear its
// pointer.
module ct_had_dbginfo_rd_ctrl #(
  parameter int NUM_FIFO  = 3,
  parameter int DBG_WIDTH = 64,
  parameter int DBG_DEPTH = 6,
  parameter int CNT_WIDTH = 3
) (
  input  logic                          forever_cpuclk,
  input  logic                          cpurst_b,
  input  logic                          req0_vld,
  input  logic [1:0]                    req0_sel,
  input  logic [CNT_WIDTH-1:0]          req0_len,
  output logic                          req0_gnt,
  input  logic                          req1_vld,
  input  logic [1:0]                    req1_sel,
  input  logic [CNT_WIDTH-1:0]          req1_len,
  output logic                          req1_gnt,
  output logic [NUM_FIFO-1:0]           dbgfifo_read_ren,
  input  logic [NUM_FIFO*DBG_WIDTH-1:0] dbgfifo_data,
  output logic                          dump_data_vld,
  output logic [DBG_WIDTH-1:0]          dump_data,
  output logic                          dump_owner,
  input  logic                          dump_data_ack,
  output logic                          dump_done,
  output logic                          dump_err,
  output logic                          busy,
  output logic [2:0]                    dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_HOLD = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [CNT_WIDTH-1:0] DEPTH_C    = CNT_WIDTH'(DBG_DEPTH);
  localparam logic [2:0]           NUM_FIFO_C = 3'(NUM_FIFO);

  state_t                 state_q;
  state_t                 state_d;
  logic                   rr_q;        // requester preferred on a tie
  logic [1:0]             sel_q;
  logic [CNT_WIDTH-1:0]   len_q;
  logic [CNT_WIDTH-1:0]   idx_q;
  logic                   err_q;

  logic                   grant_any;
  logic                   pick1;
  logic [1:0]             win_sel;
  logic [CNT_WIDTH-1:0]   win_len;
  logic [CNT_WIDTH-1:0]   win_len_clamped;
  logic                   win_sel_bad;
  logic [CNT_WIDTH-1:0]   idx_inc;
  logic                   idx_last;
  logic                   fwd_word;
  logic                   hold_ack;
  logic [DBG_WIDTH-1:0]   fifo_word;

  // Arbitration: requests are only granted in IDLE. On a tie the requester
  // pointed to by rr_q wins.
  always_comb begin
    grant_any       = (state_q == S_IDLE) && (req0_vld || req1_vld);
    pick1           = req1_vld && (!req0_vld || rr_q);
    req0_gnt        = grant_any && !pick1;
    req1_gnt        = grant_any && pick1;
    win_sel         = pick1 ? req1_sel : req0_sel;
    win_len         = pick1 ? req1_len : req0_len;
    win_len_clamped = (win_len > DEPTH_C) ? DEPTH_C : win_len;
    win_sel_bad     = ({1'b0, win_sel} >= NUM_FIFO_C);
  end

  // Word-index bookkeeping shared by the CAP and HOLD transitions.
  always_comb begin
    idx_inc  = idx_q + 1'b1;
    idx_last = (idx_inc >= DEPTH_C);
    fwd_word = (state_q == S_CAP) && (idx_q < len_q);
    hold_ack = (state_q == S_HOLD) && dump_data_ack;
  end

  // Select the output word of the latched FIFO.
  always_comb begin
    fifo_word = '0;
    for (int i = 0; i < NUM_FIFO; i++) begin
      if (sel_q == 2'(i)) begin
        fifo_word = dbgfifo_data[DBG_WIDTH*i +: DBG_WIDTH];
      end
    end
  end

  // Read pulse: one cycle in RD, only on the latched FIFO.
  always_comb begin
    dbgfifo_read_ren = '0;
    if (state_q == S_RD) begin
      for (int i = 0; i < NUM_FIFO; i++) begin
        dbgfifo_read_ren[i] = (sel_q == 2'(i));
      end
    end
  end

  // Next-state logic for the dump sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          state_d = win_sel_bad ? S_DONE : S_RD;
        end
      end
      S_RD: begin
        state_d = S_CAP;
      end
      S_CAP: begin
        if (fwd_word) begin
          state_d = S_HOLD;
        end else begin
          state_d = idx_last ? S_DONE : S_RD;
        end
      end
      S_HOLD: begin
        if (dump_data_ack) begin
          state_d = idx_last ? S_DONE : S_RD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Combinational status outputs.
  always_comb begin
    dump_done = (state_q == S_DONE);
    dump_err  = (state_q == S_DONE) && err_q;
    busy      = (state_q != S_IDLE) || grant_any;
    dbg_state = state_q;
  end

  // State register.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Round-robin pointer: after a grant, prefer the other requester.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rr_q <= 1'b0;
    end else if (grant_any) begin
      rr_q <= !pick1;
    end
  end

  // Latch the granted request's FIFO index, length, owner and error flag.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      sel_q      <= '0;
      len_q      <= '0;
      err_q      <= 1'b0;
      dump_owner <= 1'b0;
    end else if (grant_any) begin
      sel_q      <= win_sel;
      len_q      <= win_len_clamped;
      err_q      <= win_sel_bad;
      dump_owner <= pick1;
    end
  end

  // Word index: cleared on grant, advanced after each drained or accepted word.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      idx_q <= '0;
    end else if (grant_any) begin
      idx_q <= '0;
    end else if (((state_q == S_CAP) && !fwd_word) || hold_ack) begin
      idx_q <= idx_inc;
    end
  end

  // Output word register and its valid flag.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      dump_data     <= '0;
      dump_data_vld <= 1'b0;
    end else if (fwd_word) begin
      dump_data     <= fifo_word;
      dump_data_vld <= 1'b1;
    end else if (hold_ack) begin
      dump_data_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ct_had_dbginfo_rd_ctrl.sv
// Self-checking bench for ct_had_dbginfo_rd_ctrl: a small snapshot-FIFO
// model, a monitor that scores forwarded words against an expected queue,
// and a linear sequence of directed and randomized dumps.
module tb_ct_had_dbginfo_rd_ctrl;

  localparam int NF = 3;
  localparam int W  = 64;
  localparam int D  = 6;
  localparam int CW = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req0_vld, req1_vld;
  logic [1:0]    req0_sel, req1_sel;
  logic [CW-1:0] req0_len, req1_len;
  logic          req0_gnt, req1_gnt;
  logic [NF-1:0] ren;
  logic [NF*W-1:0] dbgfifo_data;
  logic          vld;
  logic [W-1:0]  data;
  logic          owner;
  logic          ack;
  logic          done;
  logic          err;
  logic          busy;
  logic [2:0]    dbg_state;

  ct_had_dbginfo_rd_ctrl #(
    .NUM_FIFO(NF), .DBG_WIDTH(W), .DBG_DEPTH(D), .CNT_WIDTH(CW)
  ) dut (
    .forever_cpuclk  (clk),
    .cpurst_b        (rst_n),
    .req0_vld        (req0_vld),
    .req0_sel        (req0_sel),
    .req0_len        (req0_len),
    .req0_gnt        (req0_gnt),
    .req1_vld        (req1_vld),
    .req1_sel        (req1_sel),
    .req1_len        (req1_len),
    .req1_gnt        (req1_gnt),
    .dbgfifo_read_ren(ren),
    .dbgfifo_data    (dbgfifo_data),
    .dump_data_vld   (vld),
    .dump_data       (data),
    .dump_owner      (owner),
    .dump_data_ack   (ack),
    .dump_done       (done),
    .dump_err        (err),
    .busy            (busy),
    .dbg_state       (dbg_state)
  );

  // ---------------- snapshot FIFO model ----------------
  logic [W-1:0] mem [NF][D];
  logic [W-1:0] dreg [NF];
  int           ptr [NF];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NF; i++) begin
        dreg[i] <= '0;
        ptr[i]  <= 0;
      end
    end else begin
      for (int i = 0; i < NF; i++) begin
        if (ren[i]) begin
          dreg[i] <= mem[i][ptr[i]];
          ptr[i]  <= (ptr[i] == D-1) ? 0 : ptr[i] + 1;
        end
      end
    end
  end

  for (genvar g = 0; g < NF; g++) begin : g_fifo_out
    assign dbgfifo_data[g*W +: W] = dreg[g];
  end

  // ---------------- checking ----------------
  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [W-1:0] exp_q[$];
  logic         exp_owner = 1'b0;
  int           cyc = 0;
  int           gnt_cnt = 0;
  int           gnt_taken = 0;
  int           gnt_who = 0;
  int           gnt_cyc = 0;
  int           ren_cnt = 0;
  int           ren_cyc[$];
  int           done_cnt = 0;
  int           done_cyc = 0;
  logic         done_err = 1'b0;

  // Expectations of the dump currently in flight.
  int           cur_sel = 0;
  int           cur_words = 0;
  logic         cur_err = 1'b0;
  int           cur_gnt_cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (ren != '0) begin
        ren_cnt++;
        ren_cyc.push_back(cyc);
        check("ren_onehot", 64'($onehot0(ren)), 64'd1);
        check("ren_during_vld", 64'(vld), 64'd0);
      end
      if (req0_gnt || req1_gnt) begin
        gnt_cnt++;
        gnt_who = int'(req1_gnt);
        gnt_cyc = cyc;
        check("gnt_exclusive", 64'(req0_gnt && req1_gnt), 64'd0);
        check("busy_at_gnt", 64'(busy), 64'd1);
      end
      if (vld) begin
        check("word_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          check("word", data, exp_q[0]);
          check("owner", 64'(owner), 64'(exp_owner));
          if (ack) void'(exp_q.pop_front());
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        done_err = err;
        check("busy_at_done", 64'(busy), 64'd1);
      end
    end
  end

  // ---------------- ack driver ----------------
  int ack_mode = 0;  // 0: tied high, 1: random, 2: held low
  initial begin
    ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ack_mode)
        0: ack = 1'b1;
        2: ack = 1'b0;
        default: ack = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_req(input int who, input logic [1:0] sel, input logic [CW-1:0] len);
    if (who == 0) begin
      req0_vld = 1'b1; req0_sel = sel; req0_len = len;
    end else begin
      req1_vld = 1'b1; req1_sel = sel; req1_len = len;
    end
  endtask

  // Wait for the next grant, check who got it, load the expected words.
  task automatic wait_gnt(input string tag, input int exp_who, input int exp_cyc);
    int n = 0;
    int sel;
    int len;
    while (gnt_cnt == gnt_taken && n < 100) begin
      @(posedge clk);
      n++;
    end
    check({tag, "_gnt_seen"}, 64'(gnt_cnt > gnt_taken), 64'd1);
    gnt_taken = gnt_cnt;
    check({tag, "_gnt_who"}, 64'(gnt_who), 64'(exp_who));
    if (exp_cyc >= 0) check({tag, "_gnt_cyc"}, 64'(gnt_cyc), 64'(exp_cyc));
    sel = (gnt_who == 1) ? int'(req1_sel) : int'(req0_sel);
    len = (gnt_who == 1) ? int'(req1_len) : int'(req0_len);
    cur_sel     = sel;
    cur_err     = (sel >= NF);
    cur_words   = cur_err ? 0 : ((len > D) ? D : len);
    cur_gnt_cyc = gnt_cyc;
    exp_owner   = 1'(gnt_who);
    for (int k = 0; k < cur_words; k++) exp_q.push_back(mem[sel][k]);
    ren_cnt = 0;
    ren_cyc.delete();
    done_cnt = 0;
    #1;
    if (gnt_who == 1) req1_vld = 1'b0;
    else              req0_vld = 1'b0;
  endtask

  // Wait for dump_done and check the dump as a whole.
  task automatic wait_done(input string tag, input int ack_hi);
    int n = 0;
    int exp_c;
    while (done_cnt == 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    check({tag, "_done_seen"}, 64'(done_cnt), 64'd1);
    check({tag, "_err"}, 64'(done_err), 64'(cur_err));
    check({tag, "_ren_count"}, 64'(ren_cnt), cur_err ? 64'd0 : 64'(D));
    check({tag, "_words_left"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_no_gnt_while_busy"}, 64'(gnt_cnt), 64'(gnt_taken));
    if (cur_err) begin
      check({tag, "_err_done_cyc"}, 64'(done_cyc), 64'(cur_gnt_cyc + 1));
    end else begin
      check({tag, "_fifo_ptr"}, 64'(ptr[cur_sel]), 64'd0);
      if (ren_cyc.size() > 0)
        check({tag, "_first_ren"}, 64'(ren_cyc[0]), 64'(cur_gnt_cyc + 1));
      if (ack_hi != 0) begin
        exp_c = cur_gnt_cyc + 1;
        for (int k = 0; k < ren_cyc.size(); k++) begin
          check($sformatf("%s_ren_cyc%0d", tag, k), 64'(ren_cyc[k]), 64'(exp_c));
          exp_c += (k < cur_words) ? 3 : 2;
        end
        check({tag, "_done_cyc"}, 64'(done_cyc), 64'(exp_c));
      end
    end
    @(negedge clk);
    check({tag, "_busy_after_done"}, 64'(busy), 64'(req0_vld || req1_vld));
    check({tag, "_ren_after_done"}, 64'(ren), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt0"}, 64'(req0_gnt), 64'd0);
    check({tag, "_gnt1"}, 64'(req1_gnt), 64'd0);
    check({tag, "_ren"}, 64'(ren), 64'd0);
    check({tag, "_vld"}, 64'(vld), 64'd0);
    check({tag, "_data"}, data, 64'd0);
    check({tag, "_owner"}, 64'(owner), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int who;
    int n;
    logic [1:0] rsel;
    logic [CW-1:0] rlen;

    req0_vld = 1'b0; req0_sel = '0; req0_len = '0;
    req1_vld = 1'b0; req1_sel = '0; req1_len = '0;
    for (int i = 0; i < NF; i++)
      for (int k = 0; k < D; k++)
        mem[i][k] = (i == 2) ? (64'hA0 + 64'(k)) : {$urandom, $urandom};

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Both requesters pending: req0 wins first tie, req1 follows after DONE.
    ack_mode = 0;
    drive_req(0, 2'd2, 3'd6);
    drive_req(1, 2'd0, 3'd2);
    wait_gnt("fifo2_full", 0, -1);
    wait_done("fifo2_full", 1);
    wait_gnt("fifo0_len2", 1, done_cyc + 1);
    wait_done("fifo0_len2", 1);

    // Both high again: alternation gives req0; FIFO0 restarts at word 0.
    drive_req(0, 2'd0, 3'd0);
    drive_req(1, 2'd0, 3'd7);
    wait_gnt("len0", 0, -1);
    wait_done("len0", 1);
    wait_gnt("len7_clamp", 1, done_cyc + 1);
    wait_done("len7_clamp", 1);

    // Out-of-range FIFO index.
    drive_req(0, 2'd3, 3'd4);
    wait_gnt("sel3", 0, -1);
    wait_done("sel3", 1);

    // Stall in HOLD, then reset mid-dump.
    ack_mode = 2;
    drive_req(1, 2'd1, 3'd6);
    wait_gnt("stall", 1, -1);
    n = 0;
    while (!vld && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("stall_vld_seen", 64'(vld), 64'd1);
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      check("stall_vld_held", 64'(vld), 64'd1);
      check("stall_no_ren", 64'(ren), 64'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ack_mode = 0;
    drive_req(0, 2'd1, 3'd3);
    wait_gnt("after_reset", 0, -1);
    wait_done("after_reset", 1);

    // Randomized dumps.
    for (int t = 0; t < 10; t++) begin
      who  = int'($urandom_range(0, 1));
      rsel = 2'($urandom_range(0, 3));
      rlen = CW'($urandom_range(0, 7));
      ack_mode = int'($urandom_range(0, 1));
      for (int i = 0; i < NF; i++)
        for (int k = 0; k < D; k++) mem[i][k] = {$urandom, $urandom};
      drive_req(who, rsel, rlen);
      wait_gnt($sformatf("rand%0d", t), who, -1);
      wait_done($sformatf("rand%0d", t), (ack_mode == 0) ? 1 : 0);
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ct_had_dbginfo_rd_ctrl.md
Name: ct_had_dbginfo_rd_ctrl

Overview:
- Read-side controller for the HAD debug-info FIFOs (per-core and common snapshot FIFOs).
- Arbitrates between two dump requesters: req0 (JTAG/DM register path) and req1 (trace/system-bus path), using round-robin.
- Sequences exactly DBG_DEPTH read pulses into the selected FIFO and forwards the first `len` words to the winner over a valid/ack handshake.
- Always drains the FIFO fully, so the FIFO read pointer returns to zero after every dump.

Parameters:
- NUM_FIFO, 3, number of debug-info FIFOs attached (max 4).
- DBG_WIDTH, 64, FIFO data width.
- DBG_DEPTH, 6, words per FIFO snapshot; FIFO pointer auto-clears at this count.
- CNT_WIDTH, 3, width of word index/length fields (must hold DBG_DEPTH).

Ports:
- forever_cpuclk  in  1  clock
- cpurst_b  in  1  asynchronous active-low reset
- req0_vld  in  1  requester 0 dump request; held until granted
- req0_sel  in  2  requester 0 FIFO index
- req0_len  in  CNT_WIDTH  requester 0 words to return
- req0_gnt  out  1  1-cycle grant pulse to requester 0
- req1_vld / req1_sel / req1_len / req1_gnt  as requester 0
- dbgfifo_read_ren  out  NUM_FIFO  one-hot read pulse per FIFO
- dbgfifo_data  in  NUM_FIFO*DBG_WIDTH  packed FIFO outputs; FIFO i occupies [DBG_WIDTH*i +: DBG_WIDTH]
- dump_data_vld  out  1  output word valid
- dump_data  out  DBG_WIDTH  output word
- dump_owner  out  1  requester owning the current dump
- dump_data_ack  in  1  consumer accepts word when high with vld
- dump_done  out  1  1-cycle end-of-dump pulse
- dump_err  out  1  valid with dump_done; sel >= NUM_FIFO
- busy  out  1  high from grant cycle until the cycle after dump_done

Behaviour:
- Reset values: all outputs 0; state IDLE; rr pointer = 0, so req0 wins the first tie.
- States: IDLE, RD, CAP, HOLD, DONE.
- IDLE:
  - If any req_vld is high, grant one requester: gnt pulses for 1 cycle; sel, len and owner are latched; idx = 0.
  - Length rule: latched len = min(req_len, DBG_DEPTH).
  - Tie-break: grant the requester not granted last; rr pointer updates on every grant.
  - If sel >= NUM_FIFO: go to DONE with err = 1. No read pulse is issued.
  - Otherwise go to RD.
- RD:
  - dbgfifo_read_ren[sel] = 1 for exactly one cycle; all other ren bits stay 0.
  - Go to CAP.
- CAP:
  - FIFO data is valid this cycle (the FIFO registers data on the ren edge).
  - If idx < len: register the word into dump_data, set vld = 1, go to HOLD.
  - Else (drain word): discard it; idx++; go to RD if idx < DBG_DEPTH, else DONE.
- HOLD:
  - dump_data_vld = 1 and dump_data stays stable until dump_data_ack.
  - On ack: vld drops next cycle; idx++; go to RD if idx < DBG_DEPTH, else DONE.
- DONE:
  - dump_done = 1 and dump_err as latched, for 1 cycle; then IDLE. busy falls the cycle after DONE.
  - No ren is asserted in DONE or in the first IDLE cycle, which gives the FIFO its pointer-clear cycle.
- Latency: grant at T; first ren at T+1; first dump_data_vld at T+3.
- Throughput: 2 cycles per drained word; 3 cycles per forwarded word with zero-wait ack.
- len = 0: full drain of DBG_DEPTH reads, no dump_data_vld, dump_done with err = 0.
- Requests arriving while busy are not granted; they stay pending and are arbitrated in IDLE after DONE.
- ack without vld is ignored. req_vld dropping before grant is legal; that requester is simply not granted.
- Reset mid-dump: all state clears immediately with no done pulse. The FIFOs share cpurst_b, so their pointers also clear.
- Invariants: dbgfifo_read_ren is at most one-hot, and exactly DBG_DEPTH ren pulses are issued per non-error grant.

Test Plan:
- req0 sel=2 len=6, FIFO2 words 0xA0..0xA5, ack tied high -> gnt at T, ren[2] at T+1/4/7/10/13/16, six words A0..A5 in order, dump_done once, err=0, owner=0.
- req1 sel=0 len=2 -> two words output, then 4 drain reads with no vld; total 6 ren pulses; a second dump of FIFO0 starts again at word 0.
- req0 and req1 both high from reset -> req0 granted first, req1 granted in the IDLE after dump_done; then both high again -> req0 granted (alternation).
- len=0 and len=7 -> 6 ren pulses each; no words for len=0, 6 words for len=7 (clamp).
- sel=3 with NUM_FIFO=3 -> gnt, no ren, dump_done=1 with dump_err=1 the next cycle.
- ack held low 5 cycles in HOLD -> dump_data stable and no ren during the stall; cpurst_b asserted mid-dump -> all outputs 0, and the next dump returns word 0.
